// File: rtl/pfd_cp_pkg.sv
// -----------------------------------------------------------------------------
// pfd_cp_pkg
// Shared types and default constants for the phase-frequency detector /
// charge-pump core (pfd_cp_core) and its helpers.
//   pfd_state_t  : detector state (BOTH only reachable with PFD_ANTIBACKLASH_EN)
//   *_DEF        : default values for the core parameters
// -----------------------------------------------------------------------------
package pfd_cp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DN   = 2'd2,
    BOTH = 2'd3
  } pfd_state_t;

  localparam int          VCTRL_W_DEF    = 16;
  localparam logic [15:0] VCTRL_INIT_DEF = 16'h6000;
  localparam int          UP_STEP_DEF    = 16;
  localparam int          DN_STEP_DEF    = 16;
`ifdef PFD_ANTIBACKLASH_EN
  localparam int          AB_CYC_DEF     = 2;
`endif

endpackage

// File: rtl/pfd_cp_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Two-flop synchronizer for an asynchronous clock-like input followed by a
// rising-edge detector in the clk domain.
// Ports:
//   clk      in  system sampling clock
//   rst_n    in  synchronous active-low reset (clears all history)
//   async_in in  asynchronous input (refclk or finalclk)
//   rise     out one-clk pulse when the synchronized input goes 0 -> 1
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Combinational so the FSM can react on the edge right after sync_q rises.
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/pfd_cp_core.sv
// -----------------------------------------------------------------------------
// pfd_cp_core
// Phase-frequency detector plus digital charge pump. Rising edges of refclk
// and finalclk (both sampled by clk) drive an IDLE/UP/DN state machine; the
// registered up/down requests are integrated into a saturating unsigned
// control-voltage code.
// Optional feature macro: PFD_ANTIBACKLASH_EN adds a BOTH state (up=down=1
// for AB_CYC cycles) after each resetting edge; vctrl holds during BOTH.
// Ports:
//   clk      in  system sampling clock (rising edge)
//   rst_n    in  synchronous active-low reset
//   d        in  PFD enable; 0 forces the detector idle
//   refclk   in  asynchronous reference clock
//   finalclk in  asynchronous feedback clock
//   up       out registered charge-pump UP request
//   down     out registered charge-pump DOWN request
//   vctrl    out control-voltage code [VCTRL_W-1:0]
// -----------------------------------------------------------------------------
module pfd_cp_core
  import pfd_cp_pkg::*;
#(
  parameter int                 VCTRL_W    = VCTRL_W_DEF,
  parameter logic [VCTRL_W-1:0] VCTRL_INIT = VCTRL_INIT_DEF,
  parameter int                 UP_STEP    = UP_STEP_DEF,
  parameter int                 DN_STEP    = DN_STEP_DEF,
  parameter logic [VCTRL_W-1:0] VMIN       = '0,
  parameter logic [VCTRL_W-1:0] VMAX       = '1
`ifdef PFD_ANTIBACKLASH_EN
  ,
  parameter int                 AB_CYC     = AB_CYC_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               d,
  input  logic               refclk,
  input  logic               finalclk,
  output logic               up,
  output logic               down,
  output logic [VCTRL_W-1:0] vctrl
);

  localparam int CW = VCTRL_W + 2;
  localparam logic signed [CW-1:0] UP_STEP_S = CW'(UP_STEP);
  localparam logic signed [CW-1:0] DN_STEP_S = CW'(DN_STEP);

  function automatic logic [VCTRL_W-1:0] sat_clamp(input logic signed [CW-1:0] v);
    if (v < $signed({2'b00, VMIN}))      return VMIN;
    else if (v > $signed({2'b00, VMAX})) return VMAX;
    else                                 return v[VCTRL_W-1:0];
  endfunction

  logic ref_rise;
  logic fb_rise;

  edge_sync u_ref_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (refclk),
    .rise     (ref_rise)
  );

  edge_sync u_fb_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (finalclk),
    .rise     (fb_rise)
  );

  pfd_state_t         state_q, state_d;
  logic               up_q, down_q;
  logic [VCTRL_W-1:0] vctrl_q, vctrl_d;
`ifdef PFD_ANTIBACKLASH_EN
  localparam int AB_W = (AB_CYC > 1) ? $clog2(AB_CYC) : 1;
  logic [AB_W-1:0] ab_cnt_q, ab_cnt_d;
`endif

  // Next-state logic. d=0 forces IDLE but the edge detectors keep running,
  // so an edge that happened while disabled cannot fire later.
  always_comb begin
    state_d = state_q;
`ifdef PFD_ANTIBACKLASH_EN
    ab_cnt_d = ab_cnt_q;
`endif
    if (!d) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (ref_rise && !fb_rise)      state_d = UP;
          else if (fb_rise && !ref_rise) state_d = DN;
`ifdef PFD_ANTIBACKLASH_EN
          else if (ref_rise && fb_rise) begin
            state_d  = BOTH;
            ab_cnt_d = AB_W'(AB_CYC - 1);
          end
`endif
        end
        UP: begin
          if (fb_rise) begin
`ifdef PFD_ANTIBACKLASH_EN
            state_d  = BOTH;
            ab_cnt_d = AB_W'(AB_CYC - 1);
`else
            state_d = IDLE;
`endif
          end
        end
        DN: begin
          if (ref_rise) begin
`ifdef PFD_ANTIBACKLASH_EN
            state_d  = BOTH;
            ab_cnt_d = AB_W'(AB_CYC - 1);
`else
            state_d = IDLE;
`endif
          end
        end
`ifdef PFD_ANTIBACKLASH_EN
        BOTH: begin
          if (ab_cnt_q == '0) state_d = IDLE;
          else                ab_cnt_d = ab_cnt_q - 1'b1;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // Charge pump: integrate the registered requests with headroom, then clamp.
  always_comb begin
    logic signed [CW-1:0] v_ext;
    logic signed [CW-1:0] v_sum;
    v_ext = $signed({2'b00, vctrl_q});
    v_sum = v_ext;
    if (up_q && !down_q)      v_sum = v_ext + UP_STEP_S;
    else if (down_q && !up_q) v_sum = v_ext - DN_STEP_S;
    vctrl_d = sat_clamp(v_sum);
  end

  // up/down decode the next state so they change on the same edge as state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      vctrl_q <= VCTRL_INIT;
`ifdef PFD_ANTIBACKLASH_EN
      ab_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      up_q    <= (state_d == UP) || (state_d == BOTH);
      down_q  <= (state_d == DN) || (state_d == BOTH);
      vctrl_q <= vctrl_d;
`ifdef PFD_ANTIBACKLASH_EN
      ab_cnt_q <= ab_cnt_d;
`endif
    end
  end

  assign up    = up_q;
  assign down  = down_q;
  assign vctrl = vctrl_q;

endmodule

// File: tb/tb_pfd_cp_core.sv
module tb_pfd_cp_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        d;
  logic        refclk;
  logic        finalclk;
  logic        up, down;
  logic [15:0] vctrl;
  logic        up_hi, down_hi;
  logic [15:0] vctrl_hi;
  logic        up_lo, down_lo;
  logic [15:0] vctrl_lo;

  int checks   = 0;
  int failures = 0;

`ifdef PFD_ANTIBACKLASH_EN
  localparam int AB_EXP = 2;
`else
  localparam int AB_EXP = 0;
`endif

  always #5 clk = ~clk;

  pfd_cp_core u_dut (
    .clk(clk), .rst_n(rst_n), .d(d), .refclk(refclk), .finalclk(finalclk),
    .up(up), .down(down), .vctrl(vctrl)
  );

  pfd_cp_core #(.VCTRL_INIT(16'hFFF8)) u_hi (
    .clk(clk), .rst_n(rst_n), .d(d), .refclk(refclk), .finalclk(finalclk),
    .up(up_hi), .down(down_hi), .vctrl(vctrl_hi)
  );

  pfd_cp_core #(.VCTRL_INIT(16'h0008)) u_lo (
    .clk(clk), .rst_n(rst_n), .d(d), .refclk(refclk), .finalclk(finalclk),
    .up(up_lo), .down(down_lo), .vctrl(vctrl_lo)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; refclk = 1'b0; finalclk = 1'b0; d = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);
  endtask

  // Raise refclk at step ref_at and finalclk at step fb_at, run n steps, then
  // drop both and let them settle; count exclusive up, down and overlap cycles.
  task automatic run_pair(input int ref_at, input int fb_at, input int n,
                          output int upc, output int dnc, output int bothc);
    upc = 0; dnc = 0; bothc = 0;
    for (int i = 0; i < n + 5; i++) begin
      if (i == ref_at) refclk = 1'b1;
      if (i == fb_at)  finalclk = 1'b1;
      if (i == n) begin refclk = 1'b0; finalclk = 1'b0; end
      tick();
      if (up && !down) upc++;
      if (down && !up) dnc++;
      if (up && down)  bothc++;
    end
  endtask

  int upc, dnc, bothc;

  initial begin
    rst_n = 1'b0; d = 1'b1; refclk = 1'b0; finalclk = 1'b0;

    // Reset state
    tick(3);
    check("rst_up",       {31'd0, up},   32'd0);
    check("rst_down",     {31'd0, down}, 32'd0);
    check("rst_vctrl",    {16'd0, vctrl},    32'h6000);
    check("rst_vctrl_hi", {16'd0, vctrl_hi}, 32'hFFF8);
    check("rst_vctrl_lo", {16'd0, vctrl_lo}, 32'h0008);
    rst_n = 1'b1;
    tick(3);

    // refclk leads by 5 cycles
    run_pair(0, 5, 12, upc, dnc, bothc);
    check("lead5_upc",   upc,   32'd5);
    check("lead5_dnc",   dnc,   32'd0);
    check("lead5_both",  bothc, AB_EXP);
    check("lead5_vctrl", {16'd0, vctrl}, 32'h6050);
    check("lead5_idle",  {30'd0, up, down}, 32'd0);

    // finalclk leads by 3 cycles
    do_reset();
    run_pair(3, 0, 10, upc, dnc, bothc);
    check("lag3_upc",   upc, 32'd0);
    check("lag3_dnc",   dnc, 32'd3);
    check("lag3_vctrl", {16'd0, vctrl}, 32'h5FD0);

    // simultaneous edges
    do_reset();
    run_pair(2, 2, 10, upc, dnc, bothc);
    check("sim_upc",   upc,   32'd0);
    check("sim_dnc",   dnc,   32'd0);
    check("sim_both",  bothc, AB_EXP);
    check("sim_vctrl", {16'd0, vctrl}, 32'h6000);

    // periodic: ref period 20 rising at 0,20,..; fb period 18 rising at 5,23,..
    // pairs give up 5,3,1 then down 1,3 -> net +5 steps
    do_reset();
    upc = 0; dnc = 0; bothc = 0;
    for (int t = 0; t < 96; t++) begin
      if (t < 90) begin
        refclk   = ((t % 20) < 10);
        finalclk = (t >= 5) && (((t - 5) % 18) < 9);
      end else begin
        refclk = 1'b0; finalclk = 1'b0;
      end
      tick();
      if (up && !down) upc++;
      if (down && !up) dnc++;
      if (up && down)  bothc++;
    end
    check("per_upc",   upc,   32'd9);
    check("per_dnc",   dnc,   32'd4);
    check("per_both",  bothc, 5 * AB_EXP);
    check("per_vctrl", {16'd0, vctrl}, 32'h6050);

    // saturation high: 4-cycle UP pulse
    do_reset();
    run_pair(0, 4, 10, upc, dnc, bothc);
    check("sat_upc",      upc, 32'd4);
    check("sat_hi_vctrl", {16'd0, vctrl_hi}, 32'hFFFF);
    check("sat_main_up",  {16'd0, vctrl},    32'h6040);
    check("sat_lo_up",    {16'd0, vctrl_lo}, 32'h0048);

    // saturation low: 4-cycle DOWN pulse
    do_reset();
    run_pair(4, 0, 10, upc, dnc, bothc);
    check("sat_dnc",      dnc, 32'd4);
    check("sat_lo_vctrl", {16'd0, vctrl_lo}, 32'h0000);
    check("sat_main_dn",  {16'd0, vctrl},    32'h5FC0);
    check("sat_hi_dn",    {16'd0, vctrl_hi}, 32'hFFB8);

    // d=0 while refclk toggles, then re-enable with refclk held high
    do_reset();
    d = 1'b0;
    upc = 0; dnc = 0;
    for (int i = 0; i < 30; i++) begin
      refclk = ((i % 6) < 3);
      tick();
      if (up)   upc++;
      if (down) dnc++;
    end
    refclk = 1'b1;
    tick(4);
    d = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (up)   upc++;
      if (down) dnc++;
    end
    check("den_upc",   upc, 32'd0);
    check("den_dnc",   dnc, 32'd0);
    check("den_vctrl", {16'd0, vctrl}, 32'h6000);
    refclk = 1'b0;
    tick(4);

    // reset mid-UP-pulse
    do_reset();
    refclk = 1'b1;
    tick(5);
    check("mid_up",    {31'd0, up}, 32'd1);
    check("mid_vctrl", {16'd0, vctrl}, 32'h6020);
    rst_n = 1'b0; refclk = 1'b0;
    tick();
    check("abort_up",    {31'd0, up},   32'd0);
    check("abort_down",  {31'd0, down}, 32'd0);
    check("abort_vctrl", {16'd0, vctrl}, 32'h6000);
    rst_n = 1'b1;
    upc = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (up) upc++;
    end
    check("post_rst_upc",   upc, 32'd0);
    check("post_rst_vctrl", {16'd0, vctrl}, 32'h6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
